result_stream_serializer: RTL and testbench

- Sits directly downstream of the systolic-array AXI4-Stream wrapper and consumes its 128-bit result stream.
- Buffers each 128-bit result in a small FIFO, then emits it as four 32-bit AXI4-Stream words, with a last flag on the fourth word.
- The upstream wrapper ignores backpressure, so this block absorbs bursts and flags any result it has to drop.

---
 rtl/result_stream_serializer.sv | 125 ++++++++++++
 tb/tb_result_stream_serializer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/result_stream_serializer.sv
// Result stream serializer: buffers 128-bit result beats in a small FIFO and
// emits each one as WORDS narrower AXI4-Stream words, least-significant first,
// with last on the final word. Upstream ignores backpressure, so beats that
// arrive while the FIFO is full are dropped and flagged with a sticky overflow.
module result_stream_serializer #(
   parameter int IN_W  = 128,
   parameter int OUT_W = 32,
   parameter int WORDS = 4,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       s_axis_valid,
   input  logic [IN_W-1:0]            s_axis_data,
   output logic                       s_axis_ready,
   output logic                       m_axis_valid,
   output logic [OUT_W-1:0]           m_axis_data,
   output logic                       m_axis_last,
   input  logic                       m_axis_ready,
   output logic                       overflow,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH+1);
   localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   logic [IN_W-1:0]  r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic [IDX_W-1:0] r_word_idx;
   logic             r_overflow;

   logic             w_out_hs;
   logic             w_pop_last;
   logic             w_push;
   logic             w_drop;
   logic [IN_W-1:0]  w_head;

   // Handshake qualifiers. A beat finishing this cycle frees its slot, so a
   // full FIFO can still accept in the same cycle it retires its head.
   assign m_axis_valid = (r_level != '0);
   assign w_out_hs     = m_axis_valid & m_axis_ready;
   assign w_pop_last   = w_out_hs & (r_word_idx == LAST_IDX);
   assign s_axis_ready = (r_level < DEPTH_L) | w_pop_last;
   assign w_push       = s_axis_valid & s_axis_ready;
   assign w_drop       = s_axis_valid & ~s_axis_ready;

   assign w_head      = r_mem[r_rd_ptr];
   assign m_axis_last = m_axis_valid & (r_word_idx == LAST_IDX);
   assign overflow    = r_overflow;
   assign level       = r_level;

   // Select the current word of the head beat, least-significant word first.
   always_comb begin
      // NOTE: default assignment first so every path drives the output and no latch is inferred.
      m_axis_data = w_head[OUT_W-1:0];
      for (int i = 0; i < WORDS; i++) begin
         if (r_word_idx == IDX_W'(i)) begin
            m_axis_data = w_head[i*OUT_W +: OUT_W];
         end
      end
   end

   // Beat storage; written only on an accepted push.
   // NOTE: the data array has no reset -- pointers and level define what is valid, so clearing it would only cost reset fan-out.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= s_axis_data;
      end
   end

   // Write pointer advances on each accepted beat, wrapping modulo DEPTH.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
      end else if (w_push) begin
         r_wr_ptr <= r_wr_ptr + 1'b1;
      end
   end

   // Read pointer moves to the next beat once its last word is taken.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rd_ptr <= '0;
      end else if (w_pop_last) begin
         r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Word index within the head beat; holds while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word_idx <= '0;
      end else if (w_out_hs) begin
         r_word_idx <= (r_word_idx == LAST_IDX) ? '0 : r_word_idx + 1'b1;
      end
   end

   // Occupancy, counting the beat being serialized; push and pop cancel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_level <= '0;
      end else if (w_push & ~w_pop_last) begin
         r_level <= r_level + 1'b1;
      end else if (w_pop_last & ~w_push) begin
         r_level <= r_level - 1'b1;
      end
   end

   // Sticky drop flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_result_stream_serializer.sv
// Self-checking bench for result_stream_serializer: directed stimulus pushes
// expected output words into a scoreboard queue; a negedge monitor pops and
// compares every output handshake.
module tb_result_stream_serializer;

   localparam int IN_W  = 128;
   localparam int OUT_W = 32;
   localparam int WORDS = 4;
   localparam int DEPTH = 4;

   logic              clk;
   logic              reset;
   logic              s_axis_valid;
   logic [IN_W-1:0]   s_axis_data;
   logic              s_axis_ready;
   logic              m_axis_valid;
   logic [OUT_W-1:0]  m_axis_data;
   logic              m_axis_last;
   logic              m_axis_ready;
   logic              overflow;
   logic [2:0]        level;

   int checks    = 0;
   int failures  = 0;
   int hs_count  = 0;
   int last_count = 0;

   logic [OUT_W:0] exp_q [$];

   result_stream_serializer #(
      .IN_W (IN_W),
      .OUT_W(OUT_W),
      .WORDS(WORDS),
      .DEPTH(DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .s_axis_valid(s_axis_valid),
      .s_axis_data (s_axis_data),
      .s_axis_ready(s_axis_ready),
      .m_axis_valid(m_axis_valid),
      .m_axis_data (m_axis_data),
      .m_axis_last (m_axis_last),
      .m_axis_ready(m_axis_ready),
      .overflow    (overflow),
      .level       (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Queue the WORDS expected output words of one beat.
   task automatic push_beat(input logic [IN_W-1:0] b);
      for (int w = 0; w < WORDS; w++) begin
         exp_q.push_back({(w == WORDS-1), b[w*OUT_W +: OUT_W]});
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int max_cyc);
      int n;
      n = 0;
      while (m_axis_valid && n < max_cyc) begin
         step();
         n++;
      end
      check("drain_done", m_axis_valid, 1'b0);
   endtask

   // Monitor: every output handshake must match the head of the scoreboard.
   always @(negedge clk) begin
      if (!reset && m_axis_valid && m_axis_ready) begin
         hs_count++;
         if (m_axis_last) last_count++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected: got word %0h last %0b with empty scoreboard", m_axis_data, m_axis_last);
         end else begin
            check("sb_word", {m_axis_last, m_axis_data}, exp_q.pop_front());
         end
      end
   end

   // Hard stop in case anything hangs.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   logic [IN_W-1:0] beat;
   logic [IN_W-1:0] fb [5];
   logic [IN_W-1:0] gb [4];
   int              idx;
   int              hs0;
   int              lc0;
   int              max_lvl;
   logic [6:0]      pat;

   initial begin
      reset        = 1'b1;
      s_axis_valid = 1'b0;
      s_axis_data  = '0;
      m_axis_ready = 1'b0;
      #2;
      check("rst_m_valid", m_axis_valid, 1'b0);
      check("rst_m_last", m_axis_last, 1'b0);
      check("rst_s_ready", s_axis_ready, 1'b1);
      check("rst_level", level, 3'd0);
      check("rst_overflow", overflow, 1'b0);
      step();
      reset = 1'b0;

      // Single beat, consumer always ready.
      beat = 128'h44444444_33333333_22222222_11111111;
      m_axis_ready = 1'b1;
      s_axis_valid = 1'b1;
      s_axis_data  = beat;
      push_beat(beat);
      step();
      s_axis_valid = 1'b0;
      check("t1_valid_after_push", m_axis_valid, 1'b1);
      check("t1_word0", m_axis_data, 32'h11111111);
      check("t1_last0", m_axis_last, 1'b0);
      check("t1_level1", level, 3'd1);
      repeat (4) step();
      check("t1_level0", level, 3'd0);
      check("t1_valid_end", m_axis_valid, 1'b0);
      check("t1_overflow", overflow, 1'b0);

      // Backpressure: ready pattern 1,0,0,1,1,0,1.
      beat = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
      pat  = 7'b1011001; // bit k is the ready value of step k
      m_axis_ready = 1'b0;
      s_axis_valid = 1'b1;
      s_axis_data  = beat;
      push_beat(beat);
      step();
      s_axis_valid = 1'b0;
      hs0 = hs_count;
      idx = 0;
      check("t2_word0", m_axis_data, 32'hAAAA0001);
      for (int k = 0; k < 7; k++) begin
         m_axis_ready = pat[k];
         step();
         if (pat[k]) idx++;
         if (idx < WORDS) begin
            check("t2_data_hold", m_axis_data, beat[idx*OUT_W +: OUT_W]);
            check("t2_last_hold", m_axis_last, (idx == WORDS-1));
         end
      end
      check("t2_handshakes", hs_count - hs0, 4);
      check("t2_level0", level, 3'd0);

      // Fill with consumer stalled, fifth beat overflows.
      m_axis_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         for (int w = 0; w < WORDS; w++) fb[i][w*OUT_W +: OUT_W] = 32'hF000_0000 | (i << 8) | w;
         s_axis_valid = 1'b1;
         s_axis_data  = fb[i];
         #1;
         check("t3_s_ready", s_axis_ready, (i < DEPTH));
         if (i < DEPTH) push_beat(fb[i]);
         step();
      end
      s_axis_valid = 1'b0;
      check("t3_level_full", level, 3'd4);
      check("t3_overflow", overflow, 1'b1);
      hs0 = hs_count;
      m_axis_ready = 1'b1;
      wait_drain(40);
      check("t3_drain_words", hs_count - hs0, 16);
      check("t3_overflow_sticky", overflow, 1'b1);
      check("t3_level0", level, 3'd0);

      // Simultaneous push and pop_last while full.
      m_axis_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         for (int w = 0; w < WORDS; w++) gb[i][w*OUT_W +: OUT_W] = 32'h6000_0000 | (i << 8) | w;
         s_axis_valid = 1'b1;
         s_axis_data  = gb[i];
         push_beat(gb[i]);
         step();
      end
      s_axis_valid = 1'b0;
      m_axis_ready = 1'b1;
      repeat (3) step();
      beat = 128'h7777_0003_7777_0002_7777_0001_7777_0000;
      s_axis_valid = 1'b1;
      s_axis_data  = beat;
      push_beat(beat);
      #1;
      check("t4_s_ready_full", s_axis_ready, 1'b1);
      check("t4_last_pending", m_axis_last, 1'b1);
      check("t4_level_before", level, 3'd4);
      step();
      s_axis_valid = 1'b0;
      check("t4_level_after", level, 3'd4);
      check("t4_overflow_unchanged", overflow, 1'b1);
      wait_drain(40);

      // Asynchronous reset mid-frame with two beats stored.
      m_axis_ready = 1'b0;
      s_axis_valid = 1'b1;
      s_axis_data  = 128'h8888_0003_8888_0002_8888_0001_8888_0000;
      push_beat(s_axis_data);
      step();
      s_axis_data  = 128'h9999_0003_9999_0002_9999_0001_9999_0000;
      push_beat(s_axis_data);
      step();
      s_axis_valid = 1'b0;
      m_axis_ready = 1'b1;
      repeat (2) step();
      m_axis_ready = 1'b0;
      #2;
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("t6_valid_in_reset", m_axis_valid, 1'b0);
      check("t6_level_in_reset", level, 3'd0);
      check("t6_overflow_cleared", overflow, 1'b0);
      check("t6_s_ready_in_reset", s_axis_ready, 1'b1);
      step();
      reset = 1'b0;
      beat = 128'hCAFE_0003_CAFE_0002_CAFE_0001_CAFE_0000;
      m_axis_ready = 1'b1;
      s_axis_valid = 1'b1;
      s_axis_data  = beat;
      push_beat(beat);
      step();
      s_axis_valid = 1'b0;
      check("t6_new_valid", m_axis_valid, 1'b1);
      check("t6_new_word0", m_axis_data, 32'hCAFE0000);
      wait_drain(10);

      // Pointer wrap: 10 beats, one every 4 cycles, consumer always ready.
      hs0 = hs_count;
      lc0 = last_count;
      max_lvl = 0;
      for (int i = 0; i < 10; i++) begin
         for (int w = 0; w < WORDS; w++) beat[w*OUT_W +: OUT_W] = 32'h5000_0000 | (i << 8) | w;
         s_axis_valid = 1'b1;
         s_axis_data  = beat;
         push_beat(beat);
         step();
         s_axis_valid = 1'b0;
         if (int'(level) > max_lvl) max_lvl = int'(level);
         for (int c = 0; c < 3; c++) begin
            step();
            if (int'(level) > max_lvl) max_lvl = int'(level);
         end
      end
      wait_drain(10);
      check("t5_max_level", max_lvl, 1);
      check("t5_words", hs_count - hs0, 40);
      check("t5_lasts", last_count - lc0, 10);
      check("t5_overflow", overflow, 1'b0);

      check("sb_empty_at_end", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
